vector_assembler: RTL and testbench

VECTOR_ASSEMBLER -- requirements
Module: vector_assembler

---
 rtl/vector_assembler_pkg.sv | 14 +
 rtl/vector_assembler_frame_timer.sv | 31 +++
 rtl/vector_assembler.sv | 131 +++++++++++++
 tb/tb_vector_assembler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_assembler_pkg.sv
// Shared types for the feature-vector path: the 16-bit component type and
// the assembler state encoding.
package vector_assembler_pkg;

    typedef logic signed [15:0] num;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_HOLD = 2'd3
    } va_state_t;

endpackage

// File: rtl/vector_assembler_frame_timer.sv
// Inter-byte idle timer: counts enabled clocks since the last clear and
// flags expiry once TIMEOUT_CYCLES-1 is reached.
module frame_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so a block left idle never wraps into a false expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/vector_assembler.sv
// Assembles big-endian 16-bit components from a byte stream into a vector
// and holds it until the consumer acknowledges.
module vector_assembler
    import vector_assembler_pkg::*;
#(
    parameter int N_COMPONENTS   = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_byte_valid,
    input  logic       new_vector_incoming,
    output num         x [N_COMPONENTS],
    output logic       vector_valid,
    input  logic       vector_ack,
    output logic       frame_error,
    output logic       overflow,
    output logic       busy,
    output va_state_t  state
);

    localparam int IW = $clog2(N_COMPONENTS) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_COMPONENTS - 1);

    logic          nvi_q;
    logic          armed;
    logic          nvi_rise;
    logic [IW-1:0] idx;
    logic [7:0]    hi_byte;
    num            shadow [N_COMPONENTS];
    logic          timer_clear;
    logic          timer_enable;
    logic          timer_expired;

    // armed keeps a level held high across reset from looking like a new frame.
    assign nvi_rise     = new_vector_incoming && !nvi_q && armed;
    assign timer_clear  = nvi_rise || rx_byte_valid;
    assign timer_enable = (state == ST_HI) || (state == ST_LO);

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            nvi_q        <= 1'b0;
            armed        <= 1'b0;
            idx          <= '0;
            hi_byte      <= '0;
            vector_valid <= 1'b0;
            frame_error  <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < N_COMPONENTS; i++) begin
                shadow[i] <= '0;
                x[i]      <= '0;
            end
        end else begin
            nvi_q       <= new_vector_incoming;
            frame_error <= 1'b0;
            if (!new_vector_incoming) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (nvi_rise) begin
                        state <= ST_HI;
                        busy  <= 1'b1;
                        idx   <= '0;
                        for (int i = 0; i < N_COMPONENTS; i++) shadow[i] <= '0;
                    end
                end
                ST_HI, ST_LO: begin
                    // Priority: restart, then an accepted byte, then timeout.
                    if (nvi_rise) begin
                        frame_error <= 1'b1;
                        state       <= ST_HI;
                        idx         <= '0;
                        for (int i = 0; i < N_COMPONENTS; i++) shadow[i] <= '0;
                    end else if (rx_byte_valid) begin
                        if (state == ST_HI) begin
                            hi_byte <= rx_byte;
                            state   <= ST_LO;
                        end else begin
                            idx <= idx + IW'(1);
                            for (int i = 0; i < N_COMPONENTS; i++) begin
                                if (idx == IW'(i)) shadow[i] <= {hi_byte, rx_byte};
                            end
                            if (idx == LAST_IDX) begin
                                for (int i = 0; i < N_COMPONENTS; i++) begin
                                    x[i] <= (idx == IW'(i)) ? {hi_byte, rx_byte} : shadow[i];
                                end
                                vector_valid <= 1'b1;
                                busy         <= 1'b0;
                                state        <= ST_HOLD;
                            end else begin
                                state <= ST_HI;
                            end
                        end
                    end else if (timer_expired) begin
                        frame_error <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (rx_byte_valid) begin
                        overflow <= 1'b1;
                    end
                    if (vector_ack) begin
                        vector_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_assembler.sv
// Bench for vector_assembler: directed scenarios plus randomized frames,
// compared every cycle against a byte-queue reference model.
module tb_vector_assembler;
    import vector_assembler_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_byte = '0;
    logic       rx_byte_valid = 1'b0;
    logic       nvi = 1'b0;
    logic       vector_ack = 1'b0;
    num         dut_x [N];
    logic       vector_valid, frame_error, overflow, busy;
    va_state_t  dut_state;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_count = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    vector_assembler #(
        .N_COMPONENTS  (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                (clk),
        .reset              (rst_n),
        .rx_byte            (rx_byte),
        .rx_byte_valid      (rx_byte_valid),
        .new_vector_incoming(nvi),
        .x                  (dut_x),
        .vector_valid       (vector_valid),
        .vector_ack         (vector_ack),
        .frame_error        (frame_error),
        .overflow           (overflow),
        .busy               (busy),
        .state              (dut_state)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  exp_q[$];
    logic [15:0] m_x [N];
    bit m_prev, m_armed, m_collect, m_hold, m_vv, m_fe, m_ovf, m_rise;
    int m_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 0; m_armed = 0; m_collect = 0; m_hold = 0;
            m_vv = 0; m_fe = 0; m_ovf = 0; m_idle = 0;
            exp_q.delete();
            for (int i = 0; i < N; i++) m_x[i] = '0;
        end else begin
            m_rise = nvi && !m_prev && m_armed;
            m_prev = nvi;
            if (!nvi) m_armed = 1;
            m_fe = 0;
            if (m_collect) begin
                if (m_rise) begin
                    m_fe = 1; exp_q.delete(); m_idle = 0;
                end else if (rx_byte_valid) begin
                    exp_q.push_back(rx_byte);
                    m_idle = 0;
                    if (exp_q.size() == 2 * N) begin
                        for (int i = 0; i < N; i++) m_x[i] = {exp_q[2*i], exp_q[2*i+1]};
                        m_vv = 1; m_hold = 1; m_collect = 0;
                        exp_q.delete();
                    end
                end else if (m_idle == TO - 1) begin
                    m_fe = 1; m_collect = 0;
                end else begin
                    m_idle++;
                end
            end else if (m_hold) begin
                if (rx_byte_valid) m_ovf = 1;
                if (vector_ack) begin m_vv = 0; m_hold = 0; end
            end else if (m_rise) begin
                m_collect = 1; exp_q.delete(); m_idle = 0;
            end
        end
    end

    function automatic va_state_t m_state();
        if (m_hold) return ST_HOLD;
        if (m_collect) return (exp_q.size() % 2 == 0) ? ST_HI : ST_LO;
        return ST_IDLE;
    endfunction

    // ---------------- per-cycle scoreboard ----------------
    always @(negedge clk) begin
        if (frame_error) fe_count++;
        if (chk_en) begin
            check_eq("vector_valid", 16'(vector_valid), 16'(m_vv));
            check_eq("frame_error", 16'(frame_error), 16'(m_fe));
            check_eq("overflow", 16'(overflow), 16'(m_ovf));
            check_eq("busy", 16'(busy), 16'(m_collect));
            check_eq("state", 16'(dut_state), 16'(m_state()));
            for (int i = 0; i < N; i++) check_eq($sformatf("x[%0d]", i), dut_x[i], m_x[i]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_byte_valid = 1'b1;
        tick();
        rx_byte_valid = 1'b0;
    endtask

    task automatic start_frame();
        nvi = 1'b1;
        tick();
        nvi = 1'b0;
    endtask

    task automatic ack_pulse();
        vector_ack = 1'b1;
        tick();
        vector_ack = 1'b0;
    endtask

    task automatic check_x(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        check_eq({tag, "_x0"}, dut_x[0], e0);
        check_eq({tag, "_x1"}, dut_x[1], e1);
        check_eq({tag, "_x2"}, dut_x[2], e2);
        check_eq({tag, "_x3"}, dut_x[3], e3);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_vv"}, 16'(vector_valid), 16'd0);
        check_eq({tag, "_fe"}, 16'(frame_error), 16'd0);
        check_eq({tag, "_ovf"}, 16'(overflow), 16'd0);
        check_eq({tag, "_busy"}, 16'(busy), 16'd0);
        check_eq({tag, "_state"}, 16'(dut_state), 16'(ST_IDLE));
        check_x(tag, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] f1 [8] = '{8'hF6, 8'hA5, 8'hFE, 8'hDA, 8'hFD, 8'h3C, 8'h00, 8'hC1};
    logic [7:0] f2 [8] = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
    logic [7:0] fr [8];

    initial begin
        int fe0, k;
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) tick();

        // Normal frame
        start_frame();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check_eq("vv_before_last", 16'(vector_valid), 16'd0);
            send_byte(f1[i]);
        end
        check_eq("normal_vv", 16'(vector_valid), 16'd1);
        check_eq("normal_busy", 16'(busy), 16'd0);
        check_x("normal", 16'hF6A5, 16'hFEDA, 16'hFD3C, 16'h00C1);

        // Hold for 10 cycles, then overflow bytes, then ack
        repeat (10) begin
            tick();
            check_x("hold", 16'hF6A5, 16'hFEDA, 16'hFD3C, 16'h00C1);
        end
        send_byte(8'h55);
        send_byte(8'hAA);
        check_eq("ovf_set", 16'(overflow), 16'd1);
        check_x("ovf", 16'hF6A5, 16'hFEDA, 16'hFD3C, 16'h00C1);
        ack_pulse();
        check_eq("ack_vv", 16'(vector_valid), 16'd0);
        check_eq("ack_state", 16'(dut_state), 16'(ST_IDLE));
        check_eq("ovf_sticky", 16'(overflow), 16'd1);
        repeat (2) tick();

        // Restart mid-frame
        fe0 = fe_count;
        start_frame();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        start_frame();
        for (int i = 0; i < 8; i++) send_byte(f2[i]);
        check_eq("restart_fe_pulses", 16'(fe_count - fe0), 16'd1);
        check_x("restart", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        ack_pulse();
        repeat (2) tick();

        // Timeout after two bytes
        start_frame();
        send_byte(8'h12);
        send_byte(8'h34);
        k = 0;
        while (!frame_error && k < 40) begin
            tick();
            k++;
        end
        check_eq("timeout_latency", 16'(k), 16'(TO));
        check_eq("timeout_state", 16'(dut_state), 16'(ST_IDLE));
        check_eq("timeout_vv", 16'(vector_valid), 16'd0);
        repeat (2) tick();

        // Async reset during byte 5, with the frame-start level held high across it
        start_frame();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        fe0 = fe_count;
        rx_byte = 8'h77;
        rx_byte_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        rx_byte_valid = 1'b0;
        nvi = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check_eq("rst_no_fe", 16'(fe_count - fe0), 16'd0);
        check_eq("rst_level_no_start", 16'(dut_state), 16'(ST_IDLE));
        nvi = 1'b0;
        tick();
        start_frame();
        for (int i = 0; i < 8; i++) begin
            fr[i] = 8'($urandom);
            send_byte(fr[i]);
        end
        check_x("post_rst", {fr[0], fr[1]}, {fr[2], fr[3]}, {fr[4], fr[5]}, {fr[6], fr[7]});
        ack_pulse();

        // Randomized frames with restarts, timeouts, collisions and stray bytes
        repeat (40) begin
            start_frame();
            for (int b = 0; b < 2 * N; b++) begin
                case ($urandom_range(0, 19))
                    0: repeat (TO + 3) tick();
                    1: start_frame();
                    2: begin
                        nvi = 1'b1; rx_byte = 8'($urandom); rx_byte_valid = 1'b1;
                        tick();
                        nvi = 1'b0; rx_byte_valid = 1'b0;
                    end
                    3: repeat (TO - 1) tick();
                    default: repeat ($urandom_range(0, 3)) tick();
                endcase
                send_byte(8'($urandom));
            end
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                vector_ack = 1'b1; rx_byte = 8'($urandom); rx_byte_valid = 1'b1;
                tick();
                vector_ack = 1'b0; rx_byte_valid = 1'b0;
            end else begin
                ack_pulse();
            end
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 2) == 0) send_byte(8'($urandom));
            if ($urandom_range(0, 4) == 0) ack_pulse();
        end
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, limit 500000 reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
